// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Divide-by-zero quotient fill; sliced down to the instance width.
    localparam logic [MAX_WIDTH-1:0] DIV0_FILL = '1;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_seq_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0] rem,
    input  logic           dvd_msb,
    input  logic [WIDTH:0] dvs,
    output logic [WIDTH:0] rem_next,
    output logic           q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+2:0] trial;

    always_comb begin
        shifted  = {rem, dvd_msb};
        trial    = {1'b0, shifted} - {2'b00, dvs};
        q_bit    = ~trial[WIDTH+2];
        rem_next = q_bit ? (WIDTH+1)'(trial) : (WIDTH+1)'(shifted);
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// Remainder output is present only when DIV_SEQ_REMAINDER_EN is defined.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH:0]   dvs_mag;
    logic             q_neg;
`ifdef DIV_SEQ_REMAINDER_EN
    logic             r_neg;
`endif

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH:0]   dvd_abs;
    logic [WIDTH:0]   dvs_abs;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    // Operand magnitudes in WIDTH+1 bits so |min| is representable.
    always_comb begin
        dvd_neg = sign_mode & dividend[WIDTH-1];
        dvs_neg = sign_mode & divisor[WIDTH-1];
        dvd_abs = dvd_neg ? (WIDTH+1)'(-{dividend[WIDTH-1], dividend}) : {1'b0, dividend};
        dvs_abs = dvs_neg ? (WIDTH+1)'(-{divisor[WIDTH-1], divisor})   : {1'b0, divisor};
    end

    div_seq_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem),
        .dvd_msb (dvd[WIDTH-1]),
        .dvs     (dvs_mag),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs_mag  <= '0;
            q_neg    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            error    <= 1'b0;
`ifdef DIV_SEQ_REMAINDER_EN
            r_neg     <= 1'b0;
            remainder <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // The done cycle still counts as busy, so start is ignored there.
                    if (done) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state    <= DONE;
                            error    <= 1'b1;
                            quotient <= WIDTH'(DIV0_FILL);
`ifdef DIV_SEQ_REMAINDER_EN
                            remainder <= dividend;
`endif
                        end else if (sign_mode && (dividend == MIN_VAL) && (divisor == '1)) begin
                            state    <= DONE;
                            error    <= 1'b1;
                            quotient <= MIN_VAL;
`ifdef DIV_SEQ_REMAINDER_EN
                            remainder <= '0;
`endif
                        end else begin
                            state   <= CALC;
                            cnt     <= CW'(WIDTH-1);
                            rem     <= '0;
                            dvd     <= WIDTH'(dvd_abs);
                            dvs_mag <= dvs_abs;
                            q_neg   <= dvd_neg ^ dvs_neg;
`ifdef DIV_SEQ_REMAINDER_EN
                            r_neg   <= dvd_neg;
`endif
                        end
                    end
                end
                CALC: begin
                    // Quotient bits shift into the working dividend as it empties.
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    quotient <= q_neg ? -dvd : dvd;
                    error    <= 1'b0;
`ifdef DIV_SEQ_REMAINDER_EN
                    remainder <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`endif
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef DIV_SEQ_REMAINDER_EN
    assign remainder = '0;
`endif

endmodule
